// File: rtl/algo_refresh_sched_pkg.sv
// Shared types and helpers for the refresh scheduler: index/debt widths and
// the period-counter reload rule.
package algo_refresh_pkg;

    localparam int BITRBNK = 2;
    localparam int BITRROW = 8;
    localparam int BITDEBT = 3;
    localparam int BITCNT  = 8;

    typedef logic [BITRBNK-1:0] rbnk_t;
    typedef logic [BITRROW-1:0] rrow_t;
    typedef logic [BITDEBT-1:0] debt_t;
    typedef logic [BITCNT-1:0]  cnt_t;

    // Half-cycle mode stretches every other period by one cycle; the reset
    // load already gives the first period REFFREQ cycles.
    function automatic cnt_t reload_val(input int reffreq, input logic reffrhf,
                                        input logic phase);
        if (reffrhf && !phase) begin
            return cnt_t'(reffreq);
        end
        return cnt_t'(reffreq - 1);
    endfunction

endpackage

// File: rtl/algo_refresh_sched_if.sv
// Access/refresh bundle between the 2RW algorithm top (master) and the
// refresh scheduler (slave).
interface algo_refresh_sched_if #(
    parameter int NUMRWPT = 2,
    parameter int BITRBNK = 2,
    parameter int BITRROW = 8,
    parameter int BITDEBT = 3
);
    // acc_vld qualifies acc_rbnk per port each cycle; while stall=1 the
    // scheduler ignores acc_vld and the master must hold its requests.
    logic                       refr;
    logic [NUMRWPT-1:0]         acc_vld;
    logic [NUMRWPT*BITRBNK-1:0] acc_rbnk;
    logic                       ready;
    logic                       stall;
    logic                       refr_go;
    logic [BITRBNK-1:0]         refr_bank;
    logic [BITRROW-1:0]         refr_row;
    logic [BITDEBT-1:0]         debt;

    modport master (
        output refr, acc_vld, acc_rbnk,
        input  ready, stall, refr_go, refr_bank, refr_row, debt
    );

    modport slave (
        input  refr, acc_vld, acc_rbnk,
        output ready, stall, refr_go, refr_bank, refr_row, debt
    );

endinterface

// File: rtl/algo_refresh_tick.sv
// Refresh credit generator: internal period counter with optional
// alternating period, or pass-through of the external refresh pin.
module algo_refresh_tick
    import algo_refresh_pkg::*;
#(
    parameter int REFFREQ = 13,
    parameter int REFFRHF = 0,
    parameter int EXTREF  = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ready,
    input  logic i_refr,
    output logic o_tick
);

    cnt_t r_cnt;
    logic r_phase;

    assign o_tick = (EXTREF != 0) ? (i_refr & i_ready)
                                  : (i_ready & (r_cnt == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= cnt_t'(REFFREQ - 1);
            r_phase <= 1'b0;
        end else if (i_ready && (EXTREF == 0)) begin
            if (r_cnt == '0) begin
                r_cnt   <= reload_val(REFFREQ, (REFFRHF != 0), r_phase);
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt - cnt_t'(1);
            end
        end
    end

endmodule

// File: rtl/algo_refresh_sched.sv
// Refresh scheduler: accumulates refresh debt, steals conflict-free cycles
// round-robin over banks, and forces a refresh with stall at the debt limit.
module algo_refresh_sched
    import algo_refresh_pkg::*;
#(
    parameter int NUMRWPT = 2,
    parameter int NUMRBNK = 4,
    parameter int BITRBNK = algo_refresh_pkg::BITRBNK,
    parameter int NUMRROW = 256,
    parameter int BITRROW = algo_refresh_pkg::BITRROW,
    parameter int REFFREQ = 13,
    parameter int REFFRHF = 0,
    parameter int EXTREF  = 0,
    parameter int MAXDEBT = 3,
    parameter int BITDEBT = algo_refresh_pkg::BITDEBT
) (
    input  logic                 clk,
    input  logic                 rst,
    algo_refresh_sched_if.slave  bus
);

    logic  r_ready;
    rbnk_t r_ptr;
    rrow_t r_row;
    debt_t r_debt;

    logic  w_tick;
    logic  w_conflict;
    logic  w_stall;
    logic  w_go;

    algo_refresh_tick #(
        .REFFREQ (REFFREQ),
        .REFFRHF (REFFRHF),
        .EXTREF  (EXTREF)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .i_ready (r_ready),
        .i_refr  (bus.refr),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < NUMRWPT; i++) begin
            if (bus.acc_vld[i] && (bus.acc_rbnk[i*BITRBNK +: BITRBNK] == r_ptr)) begin
                w_conflict = 1'b1;
            end
        end
    end

    // Gating with rst keeps a mid-operation reset cycle free of refreshes.
    assign w_stall = r_ready & ~rst & (r_debt == debt_t'(MAXDEBT));
    assign w_go    = r_ready & ~rst & (r_debt != '0) & (w_stall | ~w_conflict);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_ptr   <= '0;
            r_row   <= '0;
            r_debt  <= '0;
        end else begin
            r_ready <= 1'b1;
            r_debt  <= r_debt + debt_t'(w_tick) - debt_t'(w_go);
            if (w_go) begin
                if (r_ptr == rbnk_t'(NUMRBNK - 1)) begin
                    r_ptr <= '0;
                    r_row <= (r_row == rrow_t'(NUMRROW - 1)) ? '0 : r_row + rrow_t'(1);
                end else begin
                    r_ptr <= r_ptr + rbnk_t'(1);
                end
            end
        end
    end

    assign bus.ready     = r_ready;
    assign bus.stall     = w_stall;
    assign bus.refr_go   = w_go;
    assign bus.refr_bank = r_ptr;
    assign bus.refr_row  = r_row;
    assign bus.debt      = r_debt;

endmodule
